seq_signed_mult: RTL and testbench
==================================

SEQ_SIGNED_MULT -- requirements
Module: seq_signed_mult

Interface
REQ-001 The block SHALL have one parameter: N, default 8, operand width in bits (legal N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 The block SHALL have port a_in, input, N bits: two's-complement multiplicand.
REQ-006 The block SHALL have port b_in, input, N bits: two's-complement multiplier.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, 2N bits: two's-complement product.

Function
REQ-010 The block SHALL implement states IDLE, CALC, FIX and DONE.
REQ-011 In IDLE or DONE with start=1, the block SHALL capture a_in and b_in and enter CALC; capture SHALL be: sign = a_in[N-1] XOR b_in[N-1], with unsigned N-bit magnitudes |a_in| and |b_in|.
REQ-012 Start SHALL be ignored in CALC and FIX; operands there SHALL not change.
REQ-013 Each CALC cycle SHALL: add the 2N-bit multiplicand register to the accumulator if the multiplier LSB is 1, shift the multiplicand left 1, shift the multiplier right 1, and decrement a bit counter loaded with N.
REQ-014 CALC SHALL exit to FIX when the counter reaches 0 after the decrement, giving N CALC cycles.
REQ-015 FIX SHALL write result = accumulator if sign=0 or the accumulator is 0, else its two's-complement negation; FIX SHALL last one cycle and then enter DONE.
REQ-016 DONE SHALL assert done for exactly one cycle; with start=0 it SHALL return to IDLE, and with start=1 it SHALL accept the new operands (back-to-back).
REQ-017 Latency SHALL be fixed: start sampled at edge t gives done=1 in the cycle after edge t+N+2.
REQ-018 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-019 result SHALL hold its value from FIX until the next FIX or reset.
REQ-020 Width handling SHALL be exact: the -2^(N-1) magnitude is 2^(N-1) in N unsigned bits, and every product, including (-2^(N-1))^2, SHALL fit in 2N signed bits with no overflow.

Reset
REQ-021 While reset=1, the block SHALL immediately force: state IDLE, busy 0, done 0, result 0, and all internal registers 0.
REQ-022 A reset during CALC or FIX SHALL abort the operation with no done pulse; start SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-023 The macro SEQ_SIGNED_MULT_EARLY_TERM_EN SHALL control early termination.
REQ-024 With SEQ_SIGNED_MULT_EARLY_TERM_EN defined, CALC SHALL also exit to FIX when the shifted multiplier register becomes 0; latency SHALL be k+2, where k (1..N) is the CALC cycles used (b_in=0 gives k=1).
REQ-025 With SEQ_SIGNED_MULT_EARLY_TERM_EN undefined, latency SHALL be exactly as in REQ-017, and products SHALL be identical in both builds.

Structure
REQ-026 A shared package seq_signed_mult_pkg SHALL hold the state enum typedef (IDLE, CALC, FIX, DONE) and the default-width constant.
REQ-027 The FSM and counter SHALL be in sub-module seq_signed_mult_ctrl; the datapath registers, adder and negator SHALL be in the top module.

Verification
REQ-028 Sign mix: N=8, a=3, b=-5, start at t -> result 16'hFFF1 (-15), done at t+10, busy high t+1..t+9.
REQ-029 Extreme values: a=-128, b=-128 -> 16'h4000; a=-128, b=127 -> 16'hC080; a=-1, b=0 -> 16'h0000.
REQ-030 Ignored start: start held high during CALC -> only one done pulse, and result matches the first operands.
REQ-031 Back-to-back: start=1 in DONE with a=2, b=-3 -> next result 16'hFFFA, and no IDLE cycle in between.
REQ-032 Reset mid-op: reset at CALC cycle 4 -> busy, done and result go to 0 at once, and no done pulse follows.
REQ-033 Early termination (macro defined): a=7, b=1 -> result 16'h0007, done 3 cycles after start; without the macro, done 10 cycles after start.

Source files
------------

// File: rtl/seq_signed_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_signed_mult_pkg
// Shared definitions for the sequential signed multiplier:
//   - DEFAULT_N : default operand width in bits
//   - state_t   : controller state encoding (IDLE, CALC, FIX, DONE)
// -----------------------------------------------------------------------------
package seq_signed_mult_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : seq_signed_mult_pkg

// File: rtl/seq_signed_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_signed_mult_ctrl
// Controller for the sequential signed multiplier: state machine plus the
// CALC bit counter. Produces one-cycle datapath strobes and the registered
// busy/done status outputs.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : multiply request (honoured in IDLE and DONE only)
//   early_exit : datapath hint that the remaining multiplier bits are zero
//                (tied low by the top unless SEQ_SIGNED_MULT_EARLY_TERM_EN)
//   load       : capture operands this cycle
//   calc       : perform one shift-add step this cycle
//   fix        : apply sign correction and write the result this cycle
//   busy       : registered, high while the previous cycle was CALC or FIX
//   done       : registered, one-cycle pulse following the DONE state
//
// Configuration: SEQ_SIGNED_MULT_EARLY_TERM_EN is resolved in the top module,
// which drives early_exit accordingly.
// -----------------------------------------------------------------------------
module seq_signed_mult_ctrl
  import seq_signed_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic early_exit,
  output logic load,
  output logic calc,
  output logic fix,
  output logic busy,
  output logic done
);

  // Counter must be able to hold the value N itself.
  localparam int CW = $clog2(N + 1);

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            load_s;
  logic            calc_s;
  logic            fix_s;
  logic            busy_r;
  logic            done_r;

  // State and bit-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Status outputs are registered copies of the current state, which places
  // busy over the CALC/FIX window and done one cycle after DONE is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_r == CALC) || (state_r == FIX);
      done_r <= (state_r == DONE);
    end
  end

  // Next-state, counter update and datapath strobes.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    load_s       = 1'b0;
    calc_s       = 1'b0;
    fix_s        = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        // DONE accepts start as well so back-to-back operations skip IDLE.
        if (start) begin
          load_s       = 1'b1;
          cnt_next_s   = CW'(N);
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        calc_s     = 1'b1;
        cnt_next_s = cnt_r - CW'(1);
        // cnt_r == 1 means the counter reaches 0 after this decrement.
        if ((cnt_r == CW'(1)) || early_exit) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX: begin
        fix_s        = 1'b1;
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign load = load_s;
  assign calc = calc_s;
  assign fix  = fix_s;
  assign busy = busy_r;
  assign done = done_r;

endmodule : seq_signed_mult_ctrl

// File: rtl/seq_signed_mult.sv
// -----------------------------------------------------------------------------
// seq_signed_mult
// Sequential two's-complement multiplier. Operands are converted to sign plus
// unsigned magnitude at capture, multiplied by an N-step shift-and-add loop,
// and the sign is re-applied in a single FIX cycle.
//
// Parameters:
//   N      : operand width in bits (N >= 2)
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   start  : multiply request, accepted when idle or in the DONE cycle
//   a_in   : N-bit two's-complement multiplicand
//   b_in   : N-bit two's-complement multiplier
//   busy   : high while a multiply is in progress
//   done   : one-cycle pulse when result becomes valid
//   result : 2N-bit two's-complement product, held until the next result
//
// Configuration macro:
//   SEQ_SIGNED_MULT_EARLY_TERM_EN : when defined, CALC stops as soon as the
//   shifted multiplier has no set bits left; products are unchanged.
// -----------------------------------------------------------------------------
module seq_signed_mult
  import seq_signed_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  // Unsigned magnitude of an N-bit two's-complement value. The most negative
  // value maps to 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    logic [N-1:0] m;
    if (v[N-1]) begin
      m = ~v + {{(N-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Two's-complement negation at product width.
  function automatic logic [2*N-1:0] negate(input logic [2*N-1:0] v);
    return ~v + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  logic [2*N-1:0] mcand_r;
  logic [N-1:0]   mplier_r;
  logic [2*N-1:0] acc_r;
  logic           sign_r;
  logic [2*N-1:0] result_r;

  logic           load_s;
  logic           calc_s;
  logic           fix_s;
  logic           early_exit_s;

`ifdef SEQ_SIGNED_MULT_EARLY_TERM_EN
  // After this step's shift only bits [N-1:1] survive; if none are set the
  // remaining CALC steps would add nothing.
  assign early_exit_s = (mplier_r[N-1:1] == {(N-1){1'b0}});
`else
  assign early_exit_s = 1'b0;
`endif

  seq_signed_mult_ctrl #(
    .N (N)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .early_exit (early_exit_s),
    .load       (load_s),
    .calc       (calc_s),
    .fix        (fix_s),
    .busy       (busy),
    .done       (done)
  );

  // Operand capture, shift-and-add accumulation and sign correction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      sign_r   <= 1'b0;
      result_r <= {(2*N){1'b0}};
    end else if (load_s) begin
      mcand_r  <= {{N{1'b0}}, magnitude(a_in)};
      mplier_r <= magnitude(b_in);
      acc_r    <= {(2*N){1'b0}};
      sign_r   <= a_in[N-1] ^ b_in[N-1];
    end else if (calc_s) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= {mcand_r[2*N-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[N-1:1]};
    end else if (fix_s) begin
      // A zero magnitude stays zero regardless of the operand signs.
      if (sign_r && (acc_r != {(2*N){1'b0}})) begin
        result_r <= negate(acc_r);
      end else begin
        result_r <= acc_r;
      end
    end
  end

  assign result = result_r;

endmodule : seq_signed_mult

// File: tb/tb_seq_signed_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_mult
// Self-checking bench for seq_signed_mult (N = 8). Expected products are
// pushed to a scoreboard queue at start and popped when done pulses.
// Latency expectations follow SEQ_SIGNED_MULT_EARLY_TERM_EN when defined.
// -----------------------------------------------------------------------------
module tb_seq_signed_mult;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*N-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] sb[$];

  seq_signed_mult #(
    .N (N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference product from sign-extended operands.
  function automatic logic [2*N-1:0] model_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] x;
    logic signed [2*N-1:0] y;
    x = {{N{a[N-1]}}, a};
    y = {{N{b[N-1]}}, b};
    return x * y;
  endfunction

  // Edges from the start edge until done is visible.
  function automatic int model_lat(input logic [N-1:0] b);
`ifdef SEQ_SIGNED_MULT_EARLY_TERM_EN
    logic [N-1:0] m;
    int k;
    m = b[N-1] ? (~b + {{(N-1){1'b0}}, 1'b1}) : b;
    k = 0;
    while (m != {N{1'b0}}) begin
      m = m >> 1;
      k++;
    end
    if (k < 1) k = 1;
    return k + 2;
`else
    return N + 2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(model_prod(a, b));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_single_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    int lat;
    logic [2*N-1:0] exp_v;
    logic exp_b;
    logic exp_d;
    bit got;
    launch(a, b);
    lat = model_lat(b);
    tick();
    start = 1'b0;
    exp_v = 16'h0000;
    got = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      tick();
      exp_b = (k < lat);
      exp_d = (k == lat);
      checks++; if (busy !== exp_b) begin errors++; $display("FAIL %s_busy cyc %0d got %b want %b", name, k, busy, exp_b); end
      checks++; if (done !== exp_d) begin errors++; $display("FAIL %s_done cyc %0d got %b want %b", name, k, done, exp_d); end
      if (done === 1'b1 && sb.size() > 0) begin
        exp_v = sb.pop_front();
        got = 1'b1;
      end
      if (k >= lat) begin
        checks++;
        if (!got || result !== exp_v) begin
          errors++; $display("FAIL %s_result cyc %0d got %h want %h", name, k, result, model_prod(a, b));
        end
      end
    end
    if (!got) sb.delete();
  endtask

  task automatic test_sign_mix();
    test_single_op("mix_3x-5", 8'sd3, -8'sd5);
    test_single_op("mix_-9x11", -8'sd9, 8'sd11);
    test_single_op("mix_-6x-7", -8'sd6, -8'sd7);
    test_single_op("mix_0x-4", 8'sd0, -8'sd4);
  endtask

  task automatic test_extremes();
    test_single_op("ext_-128x-128", 8'h80, 8'h80);
    test_single_op("ext_-128x127", 8'h80, 8'h7F);
    test_single_op("ext_-1x0", 8'hFF, 8'h00);
    test_single_op("ext_127x127", 8'h7F, 8'h7F);
  endtask

  task automatic test_early_term();
    test_single_op("et_7x1", 8'sd7, 8'sd1);
    test_single_op("et_5x0", 8'sd5, 8'sd0);
  endtask

  task automatic test_ignored_start();
    int lat;
    int dones;
    logic [2*N-1:0] exp_v;
    logic exp_d;
    launch(-8'sd7, 8'sd9);
    lat = model_lat(8'sd9);
    tick();
    dones = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      if (k == lat) begin
        start = 1'b0;
      end else begin
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      tick();
      exp_d = (k == lat);
      checks++; if (done !== exp_d) begin errors++; $display("FAIL ign_done cyc %0d got %b want %b", k, done, exp_d); end
      if (done === 1'b1) begin
        dones++;
        if (sb.size() > 0) begin
          exp_v = sb.pop_front();
          checks++; if (result !== exp_v) begin errors++; $display("FAIL ign_result got %h want %h", result, exp_v); end
        end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", dones); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    logic [2*N-1:0] exp_v;
    logic exp_b;
    logic exp_d;
    launch(8'sd5, -8'sd6);
    lat1 = model_lat(-8'sd6);
    tick();
    start = 1'b0;
    for (int k = 1; k < lat1; k++) begin
      tick();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_first cyc %0d busy %b done %b want 1 0", k, busy, done); end
    end
    // Start is sampled on the same edge that leaves DONE.
    launch(8'sd2, -8'sd3);
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done1 done %b busy %b want 1 0", done, busy); end
    checks++; if (result !== exp_v) begin errors++; $display("FAIL b2b_result1 got %h want %h", result, exp_v); end
    lat2 = model_lat(-8'sd3);
    for (int j = 1; j <= lat2 + 1; j++) begin
      tick();
      exp_b = (j < lat2);
      exp_d = (j == lat2);
      checks++; if (busy !== exp_b) begin errors++; $display("FAIL b2b_busy2 cyc %0d got %b want %b", j, busy, exp_b); end
      checks++; if (done !== exp_d) begin errors++; $display("FAIL b2b_done2 cyc %0d got %b want %b", j, done, exp_d); end
      if (j == lat2 && sb.size() > 0) begin
        exp_v = sb.pop_front();
        checks++; if (result !== exp_v) begin errors++; $display("FAIL b2b_result2 got %h want %h", result, exp_v); end
      end
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_op();
    launch(8'sd3, -8'sd5);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got %b want 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mid_reset_result got %h want 0000", result); end
    sb.delete();
    #2;
    reset = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_abort cyc %0d done %b busy %b want 0 0", k, done, busy); end
    end
    // Start on the very first edge after reset release must be accepted.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_single_op("after_reset", -8'sd12, 8'sd10);
  endtask

  initial begin
    test_reset();
    test_sign_mix();
    test_extremes();
    test_early_term();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_signed_mult
